// File: rtl/mon_uart_tx.sv
// Serial hex dumper: sends a 32-bit word as eight uppercase ASCII hex characters
// (MSB nibble first), optionally followed by CR LF, as 8N1 UART frames.
module mon_uart_tx #(
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 115200,
  parameter int SEND_CRLF = 1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NCHARS = (SEND_CRLF != 0) ? 10 : 8;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    CHAR_LAST = 4'(NCHARS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [3:0]      char_reg, char_next;
  logic [31:0]     word_reg, word_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  logic [3:0]      nib [8];
  logic [7:0]      cur_char;
  logic            bit_end;
  logic            last_char;
  logic            accept;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib[gi] = word_reg[31 - 4*gi -: 4];
    end
  endgenerate

  // Chars 8/9 only exist with CR LF enabled; char_reg never reaches them otherwise.
  always_comb begin
    cur_char = 8'h0D;
    if (char_reg[3]) begin
      cur_char = char_reg[0] ? 8'h0A : 8'h0D;
    end else if (nib[char_reg[2:0]] < 4'd10) begin
      cur_char = 8'h30 + {4'h0, nib[char_reg[2:0]]};
    end else begin
      cur_char = 8'h37 + {4'h0, nib[char_reg[2:0]]};
    end
  end

  assign bit_end   = (cnt_reg == CNT_LAST);
  assign last_char = (char_reg == CHAR_LAST);
  // The final stop-bit edge doubles as an accept edge for back-to-back messages.
  assign accept    = start && ((state_reg == IDLE) ||
                               (state_reg == STOP && bit_end && last_char));

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    bit_next   = bit_reg;
    char_next  = char_reg;
    word_next  = word_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
      end
      START: begin
        cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        if (bit_end) begin
          state_next = DATA;
          bit_next   = 3'd0;
          tx_next    = cur_char[0];
        end
      end
      DATA: begin
        cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
            tx_next  = cur_char[bit_reg + 3'd1];
          end
        end
      end
      STOP: begin
        cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        if (bit_end) begin
          if (last_char) begin
            state_next = IDLE;
            char_next  = 4'd0;
            tx_next    = 1'b1;
            done_next  = 1'b1;
          end else begin
            state_next = START;
            char_next  = char_reg + 4'd1;
            tx_next    = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    if (accept) begin
      state_next = START;
      cnt_next   = '0;
      bit_next   = 3'd0;
      char_next  = 4'd0;
      word_next  = word;
      tx_next    = 1'b0;
    end

    // done and busy are never high together, even on a back-to-back accept edge.
    busy_next = (state_next != IDLE) && !done_next;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      char_reg  <= 4'd0;
      word_reg  <= 32'd0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      char_reg  <= char_next;
      word_reg  <= word_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_mon_uart_tx.sv
// Bench for mon_uart_tx: two instances (with and without CR LF) checked every cycle
// against a timeline model, plus a UART decoder and hand-computed literal checks.
module tb_mon_uart_tx;

  localparam int DIV = 10;

  logic        clk;
  logic        rst;
  logic [1:0]  start_v;
  logic [31:0] word_v [2];
  logic [1:0]  busy_v, done_v, tx_v;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int nfail_print = 0;
  int nc [2] = '{10, 8};

  mon_uart_tx #(.CLK_HZ(1000), .BAUD(100), .SEND_CRLF(1)) dut_crlf (
    .CLK100MHZ(clk), .reset(rst), .start(start_v[0]), .word(word_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));

  mon_uart_tx #(.CLK_HZ(1000), .BAUD(100), .SEND_CRLF(0)) dut_nocrlf (
    .CLK100MHZ(clk), .reset(rst), .start(start_v[1]), .word(word_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else begin
      if (nfail_print < 60)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      nfail_print++;
    end
  endtask

  function automatic string hexdump(string s);
    string r = "";
    for (int k = 0; k < s.len(); k++) r = {r, $sformatf("%02h", s[k])};
    return r;
  endfunction

  function automatic string msg_of(logic [31:0] w, int inst);
    string s;
    s = $sformatf("%08h", w);
    s = s.toupper();
    if (nc[inst] == 10) s = {s, "\r\n"};
    return s;
  endfunction

  // Model state: an accepted message is a timeline starting at its accept edge.
  bit    m_act [2];
  int    m_e0  [2];
  string m_msg [2];
  // Decoder state.
  bit    d_on  [2];
  int    d_t   [2];
  logic [7:0] d_byte [2];
  string dstr  [2];

  always @(posedge clk) begin
    logic st [2];
    logic [31:0] wd [2];
    logic rs;
    logic e_tx [2], e_busy [2], e_done [2];
    cyc++;
    rs = rst;
    for (int i = 0; i < 2; i++) begin
      st[i] = start_v[i];
      wd[i] = word_v[i];
      e_done[i] = 1'b0;
      if (rs) m_act[i] = 1'b0;
      else begin
        if (m_act[i] && (cyc - m_e0[i] == 10 * nc[i] * DIV)) begin
          m_act[i] = 1'b0;
          e_done[i] = 1'b1;
        end
        if (!m_act[i] && st[i]) begin
          m_act[i] = 1'b1;
          m_e0[i]  = cyc;
          m_msg[i] = msg_of(wd[i], i);
        end
      end
      if (m_act[i]) begin
        int off, bp, c, k;
        logic [7:0] b;
        off = cyc - m_e0[i];
        bp = off / DIV;
        c = bp / 10;
        k = bp % 10;
        b = m_msg[i][c];
        e_tx[i]   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        e_busy[i] = !e_done[i];
      end else begin
        e_tx[i]   = 1'b1;
        e_busy[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("tx[%0d]", i),   tx_v[i],   e_tx[i]);
      chk($sformatf("busy[%0d]", i), busy_v[i], e_busy[i]);
      chk($sformatf("done[%0d]", i), done_v[i], e_done[i]);
      if (rs) d_on[i] = 1'b0;
      else if (!d_on[i]) begin
        if (tx_v[i] === 1'b0) begin
          d_on[i] = 1'b1;
          d_t[i]  = 0;
        end
      end else begin
        d_t[i]++;
        if ((d_t[i] - DIV/2) % DIV == 0) begin
          int j;
          j = (d_t[i] - DIV/2) / DIV - 1;
          if (j >= 0 && j < 8) d_byte[i][j] = tx_v[i];
          else if (j == 8) begin
            chk($sformatf("stop[%0d]", i), tx_v[i], 1'b1);
            dstr[i] = $sformatf("%s%c", dstr[i], d_byte[i]);
            d_on[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(int i, logic [31:0] w, output int e0);
    @(negedge clk);
    start_v[i] = 1'b1;
    word_v[i]  = w;
    @(posedge clk);
    #2;
    e0 = cyc;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int bound, output int at);
    at = -1;
    for (int t = 0; t < bound; t++) begin
      @(posedge clk);
      #2;
      if (done_v[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk($sformatf("done_timeout[%0d]", i), 32'd0, 32'd1);
  endtask

  task automatic check_str(int i, string name, string exp);
    total++;
    if (dstr[i] == exp) begin
      passed++;
      $display("msg[%0d] %s: decoded %s", i, name, hexdump(dstr[i]));
    end else begin
      $display("FAIL %s: got %s, expected %s", name, hexdump(dstr[i]), hexdump(exp));
    end
    dstr[i] = "";
  endtask

  task automatic rand_msg(int i);
    int e0, at, len;
    logic [31:0] w;
    string exp;
    repeat ($urandom_range(0, 15)) @(negedge clk);
    w = $urandom;
    exp = msg_of(w, i);
    send(i, w, e0);
    len = 10 * nc[i] * DIV;
    for (int t = 1; t < len - 5; t++) begin
      @(negedge clk);
      word_v[i]  = $urandom;
      start_v[i] = ($urandom_range(7) == 0);
    end
    @(negedge clk);
    start_v[i] = 1'b0;
    wait_done(i, 20, at);
    chk($sformatf("rand_done_at[%0d]", i), at - e0, len);
    check_str(i, $sformatf("rand %08h", w), exp);
  endtask

  initial begin
    int e0, at, d1, d2;
    rst = 1'b1;
    start_v = 2'b11;
    word_v[0] = 32'h12345678;
    word_v[1] = 32'h9ABCDEF0;
    dstr[0] = "";
    dstr[1] = "";

    // Reset held 3 cycles with start asserted: line must stay idle.
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("rst_tx", {30'd0, tx_v}, 32'd3);
      chk("rst_busy", {30'd0, busy_v}, 32'd0);
      chk("rst_done", {30'd0, done_v}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    start_v = 2'b00;

    // Single word with CR LF.
    send(0, 32'h004000AC, e0);
    wait_done(0, 1100, at);
    chk("single_done_at", at - e0, 1000);
    chk("single_char0", {24'd0, dstr[0].len() > 0 ? dstr[0][0] : 8'h00}, 32'h30);
    check_str(0, "single", "004000AC\r\n");

    // Hex extremes without CR LF.
    send(1, 32'hFEDCBA98, e0);
    wait_done(1, 900, at);
    chk("ext1_done_at", at - e0, 800);
    check_str(1, "ext1", "FEDCBA98");
    send(1, 32'h01234567, e0);
    wait_done(1, 900, at);
    chk("ext2_done_at", at - e0, 800);
    check_str(1, "ext2", "01234567");

    // Start while busy is ignored and the latched word is kept.
    send(0, 32'h11111111, e0);
    repeat (49) @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b1;
    word_v[0]  = 32'h22222222;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 1100, at);
    chk("busy_start_done_at", at - e0, 1000);
    check_str(0, "start_while_busy", "11111111\r\n");

    // Back-to-back: start held, second start bit on the first done edge.
    @(negedge clk);
    start_v[0] = 1'b1;
    word_v[0]  = 32'hA5A5A5A5;
    @(posedge clk);
    #2;
    e0 = cyc;
    wait_done(0, 1100, d1);
    chk("b2b_tx_at_done", tx_v[0], 1'b0);
    chk("b2b_busy_at_done", busy_v[0], 1'b0);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 1100, d2);
    chk("b2b_first", d1 - e0, 1000);
    chk("b2b_second", d2 - d1, 1000);
    check_str(0, "back_to_back", "A5A5A5A5\r\nA5A5A5A5\r\n");

    // Reset mid-message at E0+37*DIV+3, then a new start two cycles later.
    send(0, 32'h0BADF00D, e0);
    repeat (372) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_tx", tx_v[0], 1'b1);
    chk("midrst_busy", busy_v[0], 1'b0);
    chk("midrst_done", done_v[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_str(0, "partial_before_reset", "0BA");
    @(posedge clk);
    send(0, 32'h5EED1234, d1);
    chk("midrst_restart_edge", d1 - e0, 375);
    wait_done(0, 1100, at);
    chk("midrst_new_done_at", at - d1, 1000);
    check_str(0, "after_reset", "5EED1234\r\n");

    // Randomized words, with word churn and ignored starts while busy.
    for (int r = 0; r < 3; r++) begin
      rand_msg(0);
      rand_msg(1);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
